e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Multi-cycle multiply/divide unit for the P6 pipelined MIPS core; sits in the E stage beside the ALU.
- Executes the mult, multu, div, divu, mthi, mtlo, mfhi and mflo instructions.
- Owns the HI/LO registers.
- Reports busy so the D-stage hazard unit can stall later MDU instructions.

Parameters:
- MULT_CYCLES, 5: cycles busy stays high for mult/multu (≥1).
- DIV_CYCLES, 10: cycles busy stays high for div/divu (≥1).

Ports:
- clk, input, 1: single system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- dataA, input, 32: rs operand.
- dataB, input, 32: rt operand.
- MDUctrl, input, 4: operation select, see Behaviour.
- start, input, 1: one-cycle strobe; the E-stage instruction is an MDU write op.
- sel_hi, input, 1: read select; 1 = HI (mfhi), 0 = LO (mflo).
- busy, output, 1: multi-cycle operation in progress.
- hi, output, 32: HI register.
- lo, output, 32: LO register.
- out, output, 32: combinational; sel_hi ? hi : lo.

Behaviour:
- MDUctrl encoding:
  - 0000 none
  - 0001 mult
  - 0010 multu
  - 0011 div
  - 0100 divu
  - 0101 mthi
  - 0110 mtlo
  - All other codes: no operation.
- Reset, asserted asynchronously at any time, including mid-operation:
  - busy=0, hi=0, lo=0, counter=0.
  - Any pending result is discarded.
- FSM states:
  - IDLE (busy=0).
  - RUN (busy=1, down-counter cnt).
- IDLE, rising edge with start=1:
  - mult/multu/div/divu: latch dataA and dataB. Set cnt=MULT_CYCLES or DIV_CYCLES. Go to RUN. busy reads 1 from the next cycle.
  - mthi: hi<=dataA on this edge. Stay IDLE.
  - mtlo: lo<=dataA on this edge. Stay IDLE.
  - none or undefined code: no state change.
- RUN, each edge: cnt decrements.
  - On the edge where cnt==1: hi/lo take the result, busy<=0, return to IDLE.
  - busy is therefore high for exactly N cycles, and the result is visible on the cycle busy first reads 0.
- start while in RUN: ignored entirely (the hazard unit must stall on start|busy). mthi/mtlo during RUN are also ignored.
- The result is computed from the latched operands, so input changes during RUN have no effect.
- mult: 64-bit signed product of dataA*dataB; hi=[63:32], lo=[31:0].
- multu: same, unsigned.
- div (signed):
  - lo = quotient, truncated toward zero.
  - hi = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- divu: unsigned quotient and remainder.
- Divide by zero (dataB==0 on div/divu):
  - Still busy for DIV_CYCLES.
  - hi and lo keep their prior values.
- out changes the same cycle as sel_hi. During RUN it shows the old HI/LO; the hazard unit stalls mfhi/mflo while busy.
- Back-to-back: start may be reasserted on the cycle busy first reads 0. The new operation starts on that edge.

Decomposition:
- Shared package/header holds:
  - MDUctrl opcode constants (MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO).
  - Default cycle counts.
  - The IDLE/RUN state encoding.
- Natural sub-module: e_mdu_calc.
  - Purely combinational.
  - Inputs: latched operands and opcode.
  - Outputs: {hi_next, lo_next} and a div0 flag.
- e_mdu itself keeps the FSM, counter, operand latches and HI/LO registers.

Test Plan:
1. mult, dataA=0xFFFFFFFE (-2), dataB=3, start pulse:
   - busy=1 for exactly 5 cycles, hi/lo unchanged meanwhile.
   - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
2. multu, same operands:
   - After 5 cycles hi=0x00000002, lo=0xFFFFFFFA.
3. div, dataA=-7 (0xFFFFFFF9), dataB=2:
   - busy for 10 cycles.
   - Then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
   - divu with the same operands gives lo=0x7FFFFFFC, hi=1.
4. mthi 0x12345678, then mtlo 0x9ABCDEF0, then div with dataB=0:
   - busy for 10 cycles.
   - hi/lo remain 0x12345678 and 0x9ABCDEF0.
   - out follows sel_hi with zero latency.
5. mult started; on cycle 2 of busy, pulse start with mtlo and then divu:
   - Both ignored; the mult result commits unchanged.
   - A divu pulsed on the first busy=0 cycle starts immediately.
6. div in progress; reset pulled low on cycle 4 of busy:
   - busy, hi and lo go to 0 immediately (asynchronously).
   - After release, no delayed result ever appears.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: opcodes,
// default latencies, FSM state encoding and a small magnitude helper.
package e_mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'b0000;
  localparam logic [3:0] MDU_MULT  = 4'b0001;
  localparam logic [3:0] MDU_MULTU = 4'b0010;
  localparam logic [3:0] MDU_DIV   = 4'b0011;
  localparam logic [3:0] MDU_DIVU  = 4'b0100;
  localparam logic [3:0] MDU_MTHI  = 4'b0101;
  localparam logic [3:0] MDU_MTLO  = 4'b0110;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Magnitude of a two's-complement word, returned unsigned so that
  // 0x80000000 maps to 2^31 without overflow.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational result generator: produces the HI/LO pair for the latched
// operation and flags a divide by zero so the caller can suppress the write.
module e_mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  op_i,
  output logic [31:0] hi_next_o,
  output logic [31:0] lo_next_o,
  output logic        div0_o
);

  logic signed [63:0] a_sx, b_sx, prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] ua, ub, ub_safe, uq, ur, sq, sr, dq, dr;

  assign a_sx   = signed'({{32{a_i[31]}}, a_i});
  assign b_sx   = signed'({{32{b_i[31]}}, b_i});
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  // Signed division is done on magnitudes so that 0x80000000 / -1 yields
  // 0x80000000 with zero remainder instead of relying on overflow behaviour.
  assign ua      = (op_i == MDU_DIV) ? mag32(a_i) : a_i;
  assign ub      = (op_i == MDU_DIV) ? mag32(b_i) : b_i;
  assign ub_safe = (ub == 32'd0) ? 32'd1 : ub;
  assign dq      = ua / ub_safe;
  assign dr      = ua % ub_safe;
  assign sq      = (a_i[31] ^ b_i[31]) ? (~dq + 32'd1) : dq;
  assign sr      = a_i[31] ? (~dr + 32'd1) : dr;
  assign uq      = dq;
  assign ur      = dr;

  // Select the result pair for the latched opcode.
  always_comb begin
    hi_next_o = 32'd0;
    lo_next_o = 32'd0;
    div0_o    = 1'b0;
    case (op_i)
      MDU_MULT: begin
        hi_next_o = prod_s[63:32];
        lo_next_o = prod_s[31:0];
      end
      MDU_MULTU: begin
        hi_next_o = prod_u[63:32];
        lo_next_o = prod_u[31:0];
      end
      MDU_DIV: begin
        hi_next_o = sr;
        lo_next_o = sq;
        div0_o    = (b_i == 32'd0);
      end
      MDU_DIVU: begin
        hi_next_o = ur;
        lo_next_o = uq;
        div0_o    = (b_i == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs mult/div for a fixed number
// of cycles while reporting busy, and handles mthi/mtlo in a single cycle.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [3:0]  MDUctrl,
  input  logic        start,
  input  logic        sel_hi,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] out
);

  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = (MAXC < 2) ? 1 : $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [31:0]      a_q, b_q, hi_q, lo_q;
  logic [3:0]       op_q;
  logic [31:0]      hi_next, lo_next;
  logic             div0;

  e_mdu_calc u_calc (
    .a_i       (a_q),
    .b_i       (b_q),
    .op_i      (op_q),
    .hi_next_o (hi_next),
    .lo_next_o (lo_next),
    .div0_o    (div0)
  );

  // Control FSM: accept a new op only in IDLE, count down in RUN, commit on the last edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= MDU_NONE;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (MDUctrl)
              MDU_MULT, MDU_MULTU: begin
                a_q     <= dataA;
                b_q     <= dataB;
                op_q    <= MDUctrl;
                cnt_q   <= MULT_CNT;
                busy_q  <= 1'b1;
                state_q <= ST_RUN;
              end
              MDU_DIV, MDU_DIVU: begin
                a_q     <= dataA;
                b_q     <= dataB;
                op_q    <= MDUctrl;
                cnt_q   <= DIV_CNT;
                busy_q  <= 1'b1;
                state_q <= ST_RUN;
              end
              MDU_MTHI: hi_q <= dataA;
              MDU_MTLO: lo_q <= dataA;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
            if (!div0) begin
              hi_q <= hi_next;
              lo_q <= lo_next;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign out  = sel_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dataA = 32'd0;
  logic [31:0] dataB = 32'd0;
  logic [3:0]  MDUctrl = 4'd0;
  logic        start = 1'b0;
  logic        sel_hi = 1'b0;
  logic        busy;
  logic [31:0] hi, lo, out;

  int checks = 0;
  int failures = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB),
    .MDUctrl(MDUctrl), .start(start), .sel_hi(sel_hi),
    .busy(busy), .hi(hi), .lo(lo), .out(out)
  );

  always #5 clk = ~clk;

  // Issue one start pulse; returns at the negedge following the start edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    MDUctrl = op; dataA = a; dataB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUctrl = MDU_NONE;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || out !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h out=%h, want all 0", busy, hi, lo, out);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Run an op and verify busy length, HI/LO stability while busy and the final result.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int ncyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] old_hi, old_lo;
    int n;
    bit stable;
    old_hi = hi; old_lo = lo;
    issue(op, a, b);
    n = 0; stable = 1'b1;
    while (busy === 1'b1 && n < 100) begin
      if (hi !== old_hi || lo !== old_lo) stable = 1'b0;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != ncyc) begin
      failures++;
      $display("FAIL %s_busy_len: got %0d cycles, want %0d", name, n, ncyc);
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL %s_hold: hi/lo changed while busy (now hi=%h lo=%h)", name, hi, lo);
    end
    checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      failures++;
      $display("FAIL %s_result: hi=%h lo=%h, want hi=%h lo=%h", name, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_mult;
    run_op("mult",  MDU_MULT,  32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", MDU_MULTU, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
  endtask

  task automatic test_div;
    run_op("div",  MDU_DIV,  32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", MDU_DIVU, 32'hFFFFFFF9, 32'd2, 10, 32'h00000001, 32'h7FFFFFFC);
    run_op("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
  endtask

  task automatic test_mt_div0;
    issue(MDU_MTHI, 32'h12345678, 32'd0);
    checks++;
    if (busy !== 1'b0 || hi !== 32'h12345678) begin
      failures++;
      $display("FAIL mthi: busy=%b hi=%h, want busy=0 hi=12345678", busy, hi);
    end
    issue(MDU_MTLO, 32'h9ABCDEF0, 32'd0);
    checks++;
    if (busy !== 1'b0 || lo !== 32'h9ABCDEF0 || hi !== 32'h12345678) begin
      failures++;
      $display("FAIL mtlo: busy=%b hi=%h lo=%h, want busy=0 hi=12345678 lo=9abcdef0", busy, hi, lo);
    end
    issue(4'b1111, 32'hAAAAAAAA, 32'h5);
    checks++;
    if (busy !== 1'b0 || hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
      failures++;
      $display("FAIL undef_op: busy=%b hi=%h lo=%h, want unchanged", busy, hi, lo);
    end
    run_op("div0", MDU_DIV, 32'd77, 32'd0, 10, 32'h12345678, 32'h9ABCDEF0);
    #2 sel_hi = 1'b1;
    #1;
    checks++;
    if (out !== 32'h12345678) begin
      failures++;
      $display("FAIL out_hi: out=%h, want 12345678", out);
    end
    sel_hi = 1'b0;
    #1;
    checks++;
    if (out !== 32'h9ABCDEF0) begin
      failures++;
      $display("FAIL out_lo: out=%h, want 9abcdef0", out);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    issue(MDU_MULT, 32'h00010000, 32'h00010000);   // now on busy cycle 1
    MDUctrl = MDU_MTLO; dataA = 32'hDEADBEEF; start = 1'b1;   // busy cycle 2
    @(negedge clk);
    MDUctrl = MDU_DIVU; dataA = 32'd1000; dataB = 32'd3;      // busy cycle 3
    @(negedge clk);
    start = 1'b0; MDUctrl = MDU_NONE; dataA = 32'd0; dataB = 32'd0;
    n = 2;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 5 || hi !== 32'h00000001 || lo !== 32'h00000000) begin
      failures++;
      $display("FAIL ignore_in_run: busy_len=%0d hi=%h lo=%h, want 5 hi=00000001 lo=00000000", n, hi, lo);
    end
    // First busy=0 cycle: restart immediately.
    MDUctrl = MDU_DIVU; dataA = 32'd100; dataB = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUctrl = MDU_NONE;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 10 || hi !== 32'd2 || lo !== 32'd14) begin
      failures++;
      $display("FAIL b2b_divu: busy_len=%0d hi=%h lo=%h, want 10 hi=00000002 lo=0000000e", n, hi, lo);
    end
  endtask

  task automatic test_async_reset;
    bit late;
    issue(MDU_DIV, 32'd500, 32'd7);           // busy cycle 1
    repeat (3) @(negedge clk);                // busy cycle 4
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL async_reset: busy=%b hi=%h lo=%h, want all 0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
    late = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) late = 1'b1;
    end
    checks++;
    if (late) begin
      failures++;
      $display("FAIL no_late_result: busy=%b hi=%h lo=%h, want all 0", busy, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt_div0();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
